// File: rtl/fifo_ctrl_1r1w_pkg.sv
// Shared state encoding for the 1R1W FIFO controller and its pointer counters.
package fifo_ctrl_1r1w_pkg;

    localparam int STATE_W = 1;

    typedef enum logic [STATE_W-1:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_ctrl_1r1w_ptr_wrap_cnt.sv
// Modulo-DEPTH counter used for FIFO pointers and the init sweep address.
// Latency: value updates one cycle after inc/clr; last is combinational from value.
// Backpressure: none; clr overrides inc, rst overrides both.
module ptr_wrap_cnt #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             last
);

    localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(DEPTH - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    assign last = (value == LAST_VAL);

    // Explicit wrap at DEPTH-1 so non-power-of-two depths never touch unused addresses.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= last ? '0 : value + ONE;
        end
    end

endmodule

// File: rtl/fifo_ctrl_1r1w.sv
// Circular-buffer FIFO controller for an external 1R1W memory; zero-fills memory after reset.
// Latency: push writes same cycle; pop_valid/pop_data one cycle after an accepted pop.
// Backpressure: push dropped while full or not ready; pop dropped while empty. Optional FIFO_CTRL_ERR_FLAG_EN adds sticky ovf/unf.
module fifo_ctrl_1r1w
    import fifo_ctrl_1r1w_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int WORD_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [8*WORD_BYTES-1:0] push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [8*WORD_BYTES-1:0] pop_data,
    output logic                    pop_valid,
    output logic                    ready,
    output logic                    full,
    output logic                    empty,
    output logic [ADDR_WIDTH:0]     count,
`ifdef FIFO_CTRL_ERR_FLAG_EN
    output logic                    ovf,
    output logic                    unf,
`endif
    output logic                    mem_re,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [8*WORD_BYTES-1:0] mem_rd_data,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [8*WORD_BYTES-1:0] mem_wr_data,
    output logic [WORD_BYTES-1:0]   mem_be
);

    localparam int                CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic                    run;
    logic                    init_inc;
    logic                    init_last;
    logic                    push_acc;
    logic                    pop_acc;
    logic                    flush_acc;
    logic                    full_int;
    logic                    empty_int;
    logic                    pop_valid_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0]   init_addr;
    logic                    wr_last_unused;
    logic                    rd_last_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        init_inc  = 1'b0;
        case (state)
            S_INIT: begin
                init_inc = !rst;
                if (init_last) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                run = !rst;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Status comes only from the registered count, so push/pop never reach full/empty.
    assign full_int  = (cnt_q == DEPTH_CNT);
    assign empty_int = (cnt_q == '0);

    // Flush wins over both requests; full/empty rules make simultaneous R/W of one address impossible.
    assign flush_acc = run && flush;
    assign push_acc  = run && !flush && push && !full_int;
    assign pop_acc   = run && !flush && pop && !empty_int;

    ptr_wrap_cnt #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_init_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (init_inc),
        .clr   (1'b0),
        .value (init_addr),
        .last  (init_last)
    );

    ptr_wrap_cnt #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (push_acc),
        .clr   (flush_acc),
        .value (wr_ptr),
        .last  (wr_last_unused)
    );

    ptr_wrap_cnt #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (pop_acc),
        .clr   (flush_acc),
        .value (rd_ptr),
        .last  (rd_last_unused)
    );

    always_ff @(posedge clk) begin
        if (rst || flush_acc) begin
            cnt_q <= '0;
        end else if (push_acc && !pop_acc) begin
            cnt_q <= cnt_q + CNT_ONE;
        end else if (pop_acc && !push_acc) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    // Not cleared by flush: a pop accepted just before a flush still delivers its word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_valid_q <= 1'b0;
        end else begin
            pop_valid_q <= pop_acc;
        end
    end

    always_comb begin
        mem_we      = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_be      = '0;
        if (!rst) begin
            if (state == S_INIT) begin
                mem_we      = 1'b1;
                mem_wr_addr = init_addr;
                mem_be      = '1;
            end else if (push_acc) begin
                mem_we      = 1'b1;
                mem_wr_addr = wr_ptr;
                mem_wr_data = push_data;
                mem_be      = '1;
            end
        end
    end

    assign mem_re      = pop_acc;
    assign mem_rd_addr = rd_ptr;
    assign pop_data    = mem_rd_data;

    // Outputs are forced to their idle values for the whole reset cycle, not just after it.
    assign pop_valid = pop_valid_q && !rst;
    assign ready     = run;
    assign full      = full_int && !rst;
    assign empty     = empty_int || rst;
    assign count     = rst ? '0 : cnt_q;

`ifdef FIFO_CTRL_ERR_FLAG_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk) begin
        if (rst || flush_acc) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (run && push && full_int) begin
                ovf_q <= 1'b1;
            end
            if (run && pop && empty_int) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl_1r1w.sv
// Directed scoreboard bench for fifo_ctrl_1r1w at ADDR_WIDTH=2, MEM_DEPTH=3, WORD_BYTES=1.
module tb_fifo_ctrl_1r1w;

    logic       clk;
    logic       rst;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic       flush;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       ready;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       mem_re;
    logic [1:0] mem_rd_addr;
    logic [7:0] mem_rd_data;
    logic       mem_we;
    logic [1:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic [0:0] mem_be;
`ifdef FIFO_CTRL_ERR_FLAG_EN
    logic       ovf;
    logic       unf;
    logic       m_ovf;
    logic       m_unf;
`endif

    int errors;
    int checks;

    int m_cnt;
    int m_wr;
    int m_rd;
    logic m_prev_pop;
    logic [7:0] sb[$];
    logic [7:0] exp_q[$];
    logic [7:0] mem [0:3];

    fifo_ctrl_1r1w #(
        .ADDR_WIDTH (2),
        .MEM_DEPTH  (3),
        .WORD_BYTES (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .flush       (flush),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .ready       (ready),
        .full        (full),
        .empty       (empty),
        .count       (count),
`ifdef FIFO_CTRL_ERR_FLAG_EN
        .ovf         (ovf),
        .unf         (unf),
`endif
        .mem_re      (mem_re),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_we      (mem_we),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_be      (mem_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we && mem_be[0]) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_re) mem_rd_data <= mem[mem_rd_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "/count"}, 32'(count), 32'(m_cnt));
        chk({tag, "/full"}, 32'(full), 32'(m_cnt == 3));
        chk({tag, "/empty"}, 32'(empty), 32'(m_cnt == 0));
`ifdef FIFO_CTRL_ERR_FLAG_EN
        chk({tag, "/ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, "/unf"}, 32'(unf), 32'(m_unf));
`endif
    endtask

    task automatic do_reset(input string tag, input logic p);
        @(negedge clk);
        rst = 1'b1; push = p; push_data = 8'hEE; pop = 1'b0; flush = 1'b0;
        m_cnt = 0; m_wr = 0; m_rd = 0; m_prev_pop = 1'b0;
        sb.delete(); exp_q.delete();
`ifdef FIFO_CTRL_ERR_FLAG_EN
        m_ovf = 1'b0; m_unf = 1'b0;
`endif
        #1;
        chk({tag, "/rst_we"}, 32'(mem_we), 32'd0);
        chk({tag, "/rst_re"}, 32'(mem_re), 32'd0);
        chk({tag, "/rst_ready"}, 32'(ready), 32'd0);
        chk({tag, "/rst_pv"}, 32'(pop_valid), 32'd0);
        chk_flags({tag, "/rst"});
        @(posedge clk); #1;
        chk({tag, "/rst_ready2"}, 32'(ready), 32'd0);
        chk_flags({tag, "/rst2"});
        @(negedge clk);
        rst = 1'b0; push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk({tag, "/init_ready"}, 32'(ready), 32'd0);
            chk({tag, "/init_we"}, 32'(mem_we), 32'd1);
            chk({tag, "/init_addr"}, 32'(mem_wr_addr), 32'(i));
            chk({tag, "/init_data"}, 32'(mem_wr_data), 32'd0);
            chk({tag, "/init_be"}, 32'(mem_be), 32'd1);
            @(negedge clk);
        end
        #1;
        chk({tag, "/ready"}, 32'(ready), 32'd1);
        chk({tag, "/ready_we"}, 32'(mem_we), 32'd0);
        chk_flags({tag, "/ready"});
    endtask

    task automatic step(input string tag, input logic p, input logic [7:0] d,
                        input logic rq, input logic f);
        logic acc_p;
        logic acc_q;
        logic [7:0] e;
        @(negedge clk);
        push = p; push_data = d; pop = rq; flush = f;
        #1;
        acc_p = p && !f && (m_cnt != 3);
        acc_q = rq && !f && (m_cnt != 0);
        chk({tag, "/pv_hold"}, 32'(pop_valid), 32'(m_prev_pop));
        chk({tag, "/we"}, 32'(mem_we), 32'(acc_p));
        if (acc_p) begin
            chk({tag, "/wr_addr"}, 32'(mem_wr_addr), 32'(m_wr));
            chk({tag, "/wr_data"}, 32'(mem_wr_data), 32'(d));
        end
        chk({tag, "/re"}, 32'(mem_re), 32'(acc_q));
        if (acc_q) chk({tag, "/rd_addr"}, 32'(mem_rd_addr), 32'(m_rd));
        if (f) begin
            m_cnt = 0; m_wr = 0; m_rd = 0;
            sb.delete();
`ifdef FIFO_CTRL_ERR_FLAG_EN
            m_ovf = 1'b0; m_unf = 1'b0;
`endif
        end else begin
`ifdef FIFO_CTRL_ERR_FLAG_EN
            if (p && m_cnt == 3) m_ovf = 1'b1;
            if (rq && m_cnt == 0) m_unf = 1'b1;
`endif
            if (acc_q) begin
                exp_q.push_back(sb.pop_front());
                m_rd = (m_rd == 2) ? 0 : m_rd + 1;
                m_cnt = m_cnt - 1;
            end
            if (acc_p) begin
                sb.push_back(d);
                m_wr = (m_wr == 2) ? 0 : m_wr + 1;
                m_cnt = m_cnt + 1;
            end
        end
        m_prev_pop = acc_q;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
        chk({tag, "/pop_valid"}, 32'(pop_valid), 32'(acc_q));
        if (acc_q) begin
            e = exp_q.pop_front();
            chk({tag, "/pop_data"}, 32'(pop_data), 32'(e));
        end
        chk({tag, "/ready"}, 32'(ready), 32'd1);
        chk_flags(tag);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; push = 1'b0; push_data = 8'h00; pop = 1'b0; flush = 1'b0;
        do_reset("rst0", 1'b0);

        step("a1", 1'b1, 8'hA1, 1'b0, 1'b0);
        step("a2", 1'b1, 8'hA2, 1'b0, 1'b0);
        step("a3", 1'b1, 8'hA3, 1'b0, 1'b0);
        step("b4_full", 1'b1, 8'hB4, 1'b0, 1'b0);
        step("pop1", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pop2", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pop3", 1'b0, 8'h00, 1'b1, 1'b0);

        step("c5_pp_empty", 1'b1, 8'hC5, 1'b1, 1'b0);
        step("pop_c5", 1'b0, 8'h00, 1'b1, 1'b0);

        step("d1", 1'b1, 8'hD1, 1'b0, 1'b0);
        step("d2", 1'b1, 8'hD2, 1'b0, 1'b0);
        step("d3", 1'b1, 8'hD3, 1'b0, 1'b0);
        step("e4_pp_full", 1'b1, 8'hE4, 1'b1, 1'b0);
        step("flush_cnt2", 1'b1, 8'h77, 1'b1, 1'b1);
        step("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        step("f1", 1'b1, 8'hF1, 1'b0, 1'b0);
        step("f2", 1'b1, 8'hF2, 1'b0, 1'b0);

        do_reset("rst_mid", 1'b1);
        step("g1", 1'b1, 8'h61, 1'b0, 1'b0);
        step("pop_g1", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
